// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and width helpers for the idle-driven clock-gating controller.
package clock_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      OFF  = 2'd1,
      WAKE = 2'd2
   } cg_state_t;

   // Width of a counter that must hold 0..n.
   function automatic int unsigned idle_cnt_w(input int unsigned idle_cycles);
      return $clog2(idle_cycles + 1);
   endfunction

   function automatic int unsigned wake_cnt_w(input int unsigned wake_cycles);
      return $clog2(wake_cycles + 1);
   endfunction

endpackage

// File: rtl/clock_gate_dom_fsm.sv
// Per-domain gating FSM: idle timeout to OFF, timed wake-up back to RUN, gate-event counter.
module clock_gate_dom_fsm
   import clock_gate_ctrl_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 16,
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             hold,
   input  logic             scan_mode,
   output logic             gate_en,
   output logic             dom_ready,
   output logic             dom_off,
   output logic [CNT_W-1:0] gate_cnt
);

   localparam int unsigned IDLE_W = idle_cnt_w(IDLE_CYCLES);
   localparam int unsigned WAKE_W = wake_cnt_w(WAKE_CYCLES);

   cg_state_t         state;
   logic [IDLE_W-1:0] idle_cnt;
   logic [WAKE_W-1:0] wake_cnt;

   // Reset returns the domain to RUN immediately, so gate_en rises with reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RUN;
         idle_cnt  <= '0;
         wake_cnt  <= '0;
         gate_cnt  <= '0;
         gate_en   <= 1'b1;
         dom_ready <= 1'b1;
         dom_off   <= 1'b0;
      end else if (!scan_mode) begin
         case (state)
            RUN: begin
               if (hold) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
                  state     <= OFF;
                  idle_cnt  <= '0;
                  gate_en   <= 1'b0;
                  dom_ready <= 1'b0;
                  dom_off   <= 1'b1;
                  if (gate_cnt != '1) gate_cnt <= gate_cnt + CNT_W'(1);
               end else begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            OFF: begin
               if (hold) begin
                  state    <= WAKE;
                  wake_cnt <= '0;
                  gate_en  <= 1'b1;
                  dom_off  <= 1'b0;
               end
            end
            WAKE: begin
               // A wake always runs to completion, regardless of hold.
               if (wake_cnt == WAKE_W'(WAKE_CYCLES - 1)) begin
                  state     <= RUN;
                  wake_cnt  <= '0;
                  idle_cnt  <= '0;
                  dom_ready <= 1'b1;
               end else begin
                  wake_cnt <= wake_cnt + WAKE_W'(1);
               end
            end
            default: begin
               state     <= RUN;
               idle_cnt  <= '0;
               wake_cnt  <= '0;
               gate_en   <= 1'b1;
               dom_ready <= 1'b1;
               dom_off   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/clock_gate_ctrl.sv
// Clock-gating controller top: one gating FSM per domain, all-off reduction and TE fanout.
module clock_gate_ctrl #(
   parameter int unsigned NUM_DOM     = 2,
   parameter int unsigned IDLE_CYCLES = 16,
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NUM_DOM-1:0]       busy,
   input  logic [NUM_DOM-1:0]       wake_req,
   input  logic                     force_on,
   input  logic                     scan_mode,
   output logic [NUM_DOM-1:0]       gate_en,
   output logic [NUM_DOM-1:0]       gate_te,
   output logic [NUM_DOM-1:0]       dom_ready,
   output logic                     all_off,
   output logic [NUM_DOM*CNT_W-1:0] gate_cnt
);

   logic [NUM_DOM-1:0] dom_off;

   for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
      clock_gate_dom_fsm #(
         .IDLE_CYCLES (IDLE_CYCLES),
         .WAKE_CYCLES (WAKE_CYCLES),
         .CNT_W       (CNT_W)
      ) u_fsm (
         .clock     (clock),
         .reset_n   (reset_n),
         .hold      (busy[i] | wake_req[i] | force_on),
         .scan_mode (scan_mode),
         .gate_en   (gate_en[i]),
         .dom_ready (dom_ready[i]),
         .dom_off   (dom_off[i]),
         .gate_cnt  (gate_cnt[i*CNT_W +: CNT_W])
      );
   end

   // Per-domain OFF flags are flops; the AND lands in the same cycle as gate_en falling.
   assign all_off = &dom_off;
   assign gate_te = {NUM_DOM{scan_mode}};

endmodule
